// File: rtl/scaler_matrix_pkg.sv
// Shared constants and helpers for the scaler matrix window path.
// The optional top-edge replication is enabled by the SCALER_MATRIX_EDGE_REPLICATE_EN macro.
package scaler_matrix_pkg;

    localparam int unsigned DefaultKernelMax       = 4;
    localparam int unsigned DefaultRamDataBitwidth = 8;

    // Ceiling log2, never less than 1 so a pointer always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // LSB of pixel (col, row) in a window packed column-major with `kernel` rows per column.
    function automatic int unsigned pix_lsb(input int unsigned width, input int unsigned kernel,
                                            input int unsigned col, input int unsigned row);
        return width * (col * kernel + row);
    endfunction

endpackage

// File: rtl/scaler_matrix_row_sel.sv
// Rotating line-RAM pointer decode: registered per-row RAM select and the read-enable mask
// that excludes the RAM currently being written.
module scaler_matrix_row_sel
    import scaler_matrix_pkg::*;
#(
    parameter int unsigned KernelMax      = DefaultKernelMax,
    parameter int unsigned RamNum         = KernelMax + 1,
    parameter int unsigned RamNumBitwidth = clog2(RamNum)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [RamNumBitwidth-1:0]                     base_i,
    output logic [KernelMax-1:0][RamNumBitwidth-1:0]      sel_o,
    output logic [RamNum-1:0]                             ram_sel_o
);

    // (a + b) mod RamNum for a < RamNum and b < RamNum: one compare-and-subtract suffices.
    function automatic logic [RamNumBitwidth-1:0] wrap_add(input logic [RamNumBitwidth-1:0] a,
                                                           input int unsigned b);
        logic [RamNumBitwidth:0] sum;
        sum = {1'b0, a} + (RamNumBitwidth + 1)'(b);
        if (sum >= (RamNumBitwidth + 1)'(RamNum)) begin
            sum = sum - (RamNumBitwidth + 1)'(RamNum);
        end
        return sum[RamNumBitwidth-1:0];
    endfunction

    logic [KernelMax-1:0][RamNumBitwidth-1:0] sel_d, sel_q;
    logic [RamNum-1:0]                        ram_sel_d, ram_sel_q;
    logic [RamNumBitwidth-1:0]                wr_idx;

    always_comb begin
        sel_d     = '0;
        ram_sel_d = '1;
        wr_idx    = wrap_add(base_i, KernelMax);
        for (int k = 0; k < KernelMax; k++) begin
            sel_d[k] = wrap_add(base_i, k);
        end
        for (int i = 0; i < RamNum; i++) begin
            ram_sel_d[i] = (wr_idx != RamNumBitwidth'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sel_q     <= '0;
            ram_sel_q <= '0;
        end else begin
            sel_q     <= sel_d;
            ram_sel_q <= ram_sel_d;
        end
    end

    assign sel_o     = sel_q;
    assign ram_sel_o = ram_sel_q;

endmodule

// File: rtl/scaler_matrix_window.sv
// KERNEL_MAX x KERNEL_MAX pixel window fed from rotating line RAMs.
// Define SCALER_MATRIX_EDGE_REPLICATE_EN to replicate the top image edge on the first lines.
module scaler_matrix_window
    import scaler_matrix_pkg::*;
#(
    parameter int unsigned KERNEL_MAX        = DefaultKernelMax,
    parameter int unsigned RAM_NUM           = KERNEL_MAX + 1,
    parameter int unsigned RAM_NUM_BITWIDTH  = clog2(RAM_NUM),
    parameter int unsigned RAM_DATA_BITWIDTH = DefaultRamDataBitwidth
) (
    input  logic                                                   core_clk,
    input  logic                                                   core_rst_n,
    input  logic                                                   frame_start,
    input  logic                                                   line_start,
    output logic [RAM_NUM-1:0]                                     ram_sel,
    input  logic                                                   ram_read_rsp_en,
    input  logic [RAM_DATA_BITWIDTH*RAM_NUM-1:0]                   ram_read_rsp_data,
    input  logic                                                   matrix_ram_read_repeat,
    input  logic                                                   matrix_ram_read_done,
    output logic                                                   matrix_ram_read_rsp_en,
    output logic                                                   matrix_ram_read_rsp_full,
    output logic [RAM_DATA_BITWIDTH*KERNEL_MAX*KERNEL_MAX-1:0]     matrix_ram_read_rsp_pixel
);

    localparam int unsigned PixW  = RAM_DATA_BITWIDTH;
    localparam int unsigned ColW  = PixW * KERNEL_MAX;
    localparam int unsigned WinW  = ColW * KERNEL_MAX;
    localparam int unsigned FillW = clog2(KERNEL_MAX + 1);

    if (KERNEL_MAX < 2 || KERNEL_MAX > 8) begin : g_bad_kernel
        $error("scaler_matrix_window: KERNEL_MAX must be in 2..8");
    end
    if (RAM_NUM < KERNEL_MAX + 1) begin : g_bad_ram_num
        $error("scaler_matrix_window: RAM_NUM must exceed KERNEL_MAX");
    end

    logic line_step;
    assign line_step = matrix_ram_read_done & ~matrix_ram_read_repeat;

    // Line rotation pointer
    logic [RAM_NUM_BITWIDTH-1:0] base_d, base_q;

    always_comb begin
        base_d = base_q;
        if (frame_start) begin
            base_d = '0;
        end else if (line_step) begin
            base_d = (base_q == RAM_NUM_BITWIDTH'(RAM_NUM - 1)) ? '0 : base_q + 1'b1;
        end
    end

    logic [KERNEL_MAX-1:0][RAM_NUM_BITWIDTH-1:0] sel;

    scaler_matrix_row_sel #(
        .KernelMax      (KERNEL_MAX),
        .RamNum         (RAM_NUM),
        .RamNumBitwidth (RAM_NUM_BITWIDTH)
    ) u_row_sel (
        .clk_i     (core_clk),
        .rst_ni    (core_rst_n),
        .base_i    (base_q),
        .sel_o     (sel),
        .ram_sel_o (ram_sel)
    );

    // Reorder the RAM response into window row order; an out-of-range select reads as 0.
    logic [KERNEL_MAX-1:0][PixW-1:0] col_raw, col_new;

    always_comb begin
        col_raw = '0;
        for (int k = 0; k < KERNEL_MAX; k++) begin
            for (int i = 0; i < RAM_NUM; i++) begin
                if (sel[k] == RAM_NUM_BITWIDTH'(i)) begin
                    col_raw[k] = ram_read_rsp_data[i*PixW +: PixW];
                end
            end
        end
    end

`ifdef SCALER_MATRIX_EDGE_REPLICATE_EN
    localparam int unsigned RowsW = clog2(KERNEL_MAX);

    logic [RowsW-1:0] rows_valid_d, rows_valid_q;

    always_comb begin
        rows_valid_d = rows_valid_q;
        if (frame_start) begin
            rows_valid_d = '0;
        end else if (line_step && rows_valid_q != RowsW'(KERNEL_MAX - 1)) begin
            rows_valid_d = rows_valid_q + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            rows_valid_q <= '0;
        end else begin
            rows_valid_q <= rows_valid_d;
        end
    end

    // Rows above the first real image line copy the topmost real line.
    always_comb begin
        col_new = col_raw;
        for (int r = 0; r < KERNEL_MAX - 1; r++) begin
            if (rows_valid_q == RowsW'(r)) begin
                for (int k = 0; k < KERNEL_MAX - 1 - r; k++) begin
                    col_new[k] = col_raw[KERNEL_MAX-1-r];
                end
            end
        end
    end
`else
    assign col_new = col_raw;
`endif

    // Window shift and column fill tracking
    logic [WinW-1:0]  window_d, window_q;
    logic [FillW-1:0] col_fill_d, col_fill_q;
    logic             full_q, rsp_en_q;

    always_comb begin
        window_d = window_q;
        if (ram_read_rsp_en) begin
            for (int c = 0; c < KERNEL_MAX - 1; c++) begin
                window_d[pix_lsb(PixW, KERNEL_MAX, c, 0) +: ColW] =
                    window_q[pix_lsb(PixW, KERNEL_MAX, c + 1, 0) +: ColW];
            end
            window_d[pix_lsb(PixW, KERNEL_MAX, KERNEL_MAX - 1, 0) +: ColW] = col_new;
        end
    end

    always_comb begin
        col_fill_d = col_fill_q;
        if (line_start) begin
            col_fill_d = ram_read_rsp_en ? FillW'(1) : '0;
        end else if (ram_read_rsp_en && col_fill_q != FillW'(KERNEL_MAX)) begin
            col_fill_d = col_fill_q + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            base_q     <= '0;
            window_q   <= '0;
            col_fill_q <= '0;
            full_q     <= 1'b0;
            rsp_en_q   <= 1'b0;
        end else begin
            base_q     <= base_d;
            window_q   <= window_d;
            col_fill_q <= col_fill_d;
            full_q     <= (col_fill_d == FillW'(KERNEL_MAX));
            rsp_en_q   <= ram_read_rsp_en;
        end
    end

    assign matrix_ram_read_rsp_en    = rsp_en_q;
    assign matrix_ram_read_rsp_full  = full_q;
    assign matrix_ram_read_rsp_pixel = window_q;

endmodule

// File: tb/tb_scaler_matrix_window.sv
// Directed bench for scaler_matrix_window: a KERNEL_MAX=4 instance and a KERNEL_MAX=6 instance.
module tb_scaler_matrix_window;

    logic core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // KERNEL_MAX = 4 instance
    logic         rst_n, frame_start, line_start, rsp_en, rd_repeat, done;
    logic [39:0]  rsp_data;
    logic [4:0]   ram_sel4;
    logic         o_en4, o_full4;
    logic [127:0] pix4;

    scaler_matrix_window #(
        .KERNEL_MAX (4)
    ) u_dut4 (
        .core_clk                  (core_clk),
        .core_rst_n                (rst_n),
        .frame_start               (frame_start),
        .line_start                (line_start),
        .ram_sel                   (ram_sel4),
        .ram_read_rsp_en           (rsp_en),
        .ram_read_rsp_data         (rsp_data),
        .matrix_ram_read_repeat    (rd_repeat),
        .matrix_ram_read_done      (done),
        .matrix_ram_read_rsp_en    (o_en4),
        .matrix_ram_read_rsp_full  (o_full4),
        .matrix_ram_read_rsp_pixel (pix4)
    );

    // KERNEL_MAX = 6 instance
    logic         rst6_n, frame_start6, line_start6, rsp_en6, rd_repeat6, done6;
    logic [55:0]  rsp_data6;
    logic [6:0]   ram_sel6;
    logic         o_en6, o_full6;
    logic [287:0] pix6;

    scaler_matrix_window #(
        .KERNEL_MAX (6),
        .RAM_NUM    (7)
    ) u_dut6 (
        .core_clk                  (core_clk),
        .core_rst_n                (rst6_n),
        .frame_start               (frame_start6),
        .line_start                (line_start6),
        .ram_sel                   (ram_sel6),
        .ram_read_rsp_en           (rsp_en6),
        .ram_read_rsp_data         (rsp_data6),
        .matrix_ram_read_repeat    (rd_repeat6),
        .matrix_ram_read_done      (done6),
        .matrix_ram_read_rsp_en    (o_en6),
        .matrix_ram_read_rsp_full  (o_full6),
        .matrix_ram_read_rsp_pixel (pix6)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    task automatic pulse_done6();
        done6 = 1'b1;
        tick();
        done6 = 1'b0;
        tick();
    endtask

    logic [4:0] exp_seq [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

`ifdef SCALER_MATRIX_EDGE_REPLICATE_EN
    localparam logic [31:0] ExpEdge0 = 32'hAAAAAAAA;
    localparam logic [31:0] ExpEdge1 = 32'h05AAAAAA;
`else
    localparam logic [31:0] ExpEdge0 = 32'hAA030201;
    localparam logic [31:0] ExpEdge1 = 32'h05AA0302;
`endif

    localparam logic [127:0] ExpWin = 128'h60646362_50545352_40444342_30343332;

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; line_start = 1'b0; rsp_en = 1'b0;
        rd_repeat = 1'b0; done = 1'b0; rsp_data = '0;
        rst6_n = 1'b0; frame_start6 = 1'b0; line_start6 = 1'b0; rsp_en6 = 1'b0;
        rd_repeat6 = 1'b0; done6 = 1'b0; rsp_data6 = '0;
        repeat (3) tick();

        check_eq("rst_ram_sel4", 512'(ram_sel4), 512'(0));
        check_eq("rst_en4", 512'(o_en4), 512'(0));
        check_eq("rst_full4", 512'(o_full4), 512'(0));
        check_eq("rst_pix4", 512'(pix4), 512'(0));
        check_eq("rst_ram_sel6", 512'(ram_sel6), 512'(0));

        rst_n = 1'b1;
        rst6_n = 1'b1;
        tick();
        check_eq("init_sel4", 512'(ram_sel4), 512'(5'b01111));
        check_eq("init_sel6", 512'(ram_sel6), 512'(7'b0111111));

        // Rotation through all five RAMs and back
        for (int i = 0; i < 5; i++) begin
            pulse_done();
            check_eq($sformatf("rot_sel%0d", i), 512'(ram_sel4), 512'(exp_seq[i]));
        end

        // Move to base 2: rows come from RAMs 2,3,4,0
        pulse_done();
        pulse_done();
        check_eq("base2_sel", 512'(ram_sel4), 512'(5'b11101));

        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < 5; i++) begin
                rsp_data[i*8 +: 8] = 8'((j + 1) * 16 + i);
            end
            rsp_en = 1'b1;
            tick();
            check_eq($sformatf("col%0d_en", j), 512'(o_en4), 512'(1));
            check_eq($sformatf("col%0d_full", j), 512'(o_full4), 512'(j >= 3));
            if (j == 0) begin
                check_eq("col0_reorder", 512'(pix4[96 +: 32]), 512'(32'h10141312));
            end
        end
        rsp_en = 1'b0;
        tick();
        check_eq("idle_en", 512'(o_en4), 512'(0));
        check_eq("idle_full", 512'(o_full4), 512'(1));
        check_eq("window6", 512'(pix4), 512'(ExpWin));

        // line_start coinciding with a column counts that column
        line_start = 1'b1;
        rsp_en = 1'b1;
        tick();
        line_start = 1'b0;
        check_eq("ls_coinc_full", 512'(o_full4), 512'(0));
        repeat (3) tick();
        rsp_en = 1'b0;
        check_eq("ls_refill_full", 512'(o_full4), 512'(1));

        // Repeated line does not rotate
        rd_repeat = 1'b1;
        pulse_done();
        rd_repeat = 1'b0;
        check_eq("repeat_sel", 512'(ram_sel4), 512'(5'b11101));

        pulse_done();
        check_eq("base3_sel", 512'(ram_sel4), 512'(5'b11011));
        frame_start = 1'b1;
        done = 1'b1;
        tick();
        frame_start = 1'b0;
        done = 1'b0;
        tick();
        check_eq("frame_prio_sel", 512'(ram_sel4), 512'(5'b01111));

        // Top-edge behaviour on the first lines of a frame
        rsp_data = {8'h05, 8'hAA, 8'h03, 8'h02, 8'h01};
        rsp_en = 1'b1;
        tick();
        rsp_en = 1'b0;
        check_eq("edge_line0", 512'(pix4[96 +: 32]), 512'(ExpEdge0));
        pulse_done();
        check_eq("edge_base1_sel", 512'(ram_sel4), 512'(5'b11110));
        rsp_en = 1'b1;
        tick();
        rsp_en = 1'b0;
        check_eq("edge_line1", 512'(pix4[96 +: 32]), 512'(ExpEdge1));

        // KERNEL_MAX = 6: seven lines wrap the pointer
        for (int i = 0; i < 7; i++) begin
            pulse_done6();
            if (i == 0) begin
                check_eq("k6_base1_sel", 512'(ram_sel6), 512'(7'b1111110));
            end
        end
        check_eq("k6_wrap_sel", 512'(ram_sel6), 512'(7'b0111111));

        line_start6 = 1'b1;
        tick();
        line_start6 = 1'b0;
        rsp_data6 = 56'h26252423222120;
        rsp_en6 = 1'b1;
        repeat (6) tick();
        rsp_en6 = 1'b0;
        check_eq("k6_full", 512'(o_full6), 512'(1));
        check_eq("k6_newest", 512'(pix6[240 +: 48]), 512'(48'h252423222120));

        // Reset mid-line clears everything on the next edge
        rsp_en6 = 1'b1;
        rst6_n = 1'b0;
        tick();
        rsp_en6 = 1'b0;
        check_eq("k6_rst_sel", 512'(ram_sel6), 512'(0));
        check_eq("k6_rst_en", 512'(o_en6), 512'(0));
        check_eq("k6_rst_full", 512'(o_full6), 512'(0));
        check_eq("k6_rst_pix", 512'(pix6), 512'(0));
        rst6_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
